fir_out_decimator: RTL and testbench
====================================

Name: fir_out_decimator

Overview:
Downstream stage of the 4-tap FIR filter. It takes the filter's 8-bit output sample stream, which runs with no backpressure and is qualified by a valid strobe. It decimates by 2^LOG2_DEC using accumulate-and-dump (boxcar average), buffers the decimated samples in a small FIFO and hands them to the consumer over a valid/ready handshake. Samples that arrive while the FIFO is full are dropped and counted, because the FIR cannot be stalled.

Parameters:
DATA_W, 8, sample width in and out (unsigned)
LOG2_DEC, 2, log2 of decimation factor D; legal range 0..4 (D = 1..16)
FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2
CNT_W, 8, width of the saturating drop counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  FIR output sample valid this cycle
in_data  in  DATA_W  FIR output sample (unsigned)
out_valid  out  1  FIFO head holds a decimated sample
out_data  out  DATA_W  FIFO head sample
out_ready  in  1  consumer accepts head this cycle
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: at least one decimated sample dropped
drop_cnt  out  CNT_W  number of dropped samples, saturates at all-ones

Behaviour:
- Reset (rst=1 at posedge) sets: acc=0, phase count=0, FIFO empty, out_valid=0, out_data=0, level=0, overflow=0, drop_cnt=0. Reset has priority over every other event and abandons a partial accumulation.
- Accumulator width is DATA_W+LOG2_DEC, so the sum cannot overflow. The phase counter runs 0..D-1 and advances only on in_valid. in_valid=0 cycles are ignored: no advance, no accumulation.
- On in_valid with phase<D-1: acc <= acc+in_data; phase <= phase+1.
- On in_valid with phase==D-1 (the dump):
  - sum = acc+in_data; result = sum>>LOG2_DEC.
  - Push result into the FIFO. acc <= 0 and phase <= 0 regardless of push success.
- With LOG2_DEC=0, every valid input is a dump and the result is in_data.
- Push succeeds if FIFO is not full, or if a pop occurs in the same cycle (simultaneous push+pop on full leaves level unchanged).
- Push fails when the FIFO is full and there is no pop: sample discarded, overflow <= 1, drop_cnt increments unless already all-ones.
- Pop = out_valid & out_ready. It removes the head, and the next entry appears on out_data in the following cycle.
- out_valid = (level != 0), registered. out_data shows the head entry and holds stable while out_valid=1 and out_ready=0.
- A pop when empty is ignored.
- Latency: a pushed sample is visible on out_valid/out_data the cycle after the dump edge, even when the FIFO was empty. There is no same-cycle bypass.
- level updates on the same edge as push/pop: +1 push only, -1 pop only, unchanged for both or neither.
- FIFO read/write pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by the extra level bit.
- overflow and drop_cnt clear only on rst.

Optional Feature:
Macro FIR_DEC_ROUND_EN.
- Defined: result = (sum + 2^(LOG2_DEC-1)) >> LOG2_DEC for LOG2_DEC>0, giving round-half-up. Result is clamped to 2^DATA_W-1 (not reachable for legal params; the clamp is kept anyway). LOG2_DEC=0 unchanged.
- Undefined: result is truncated, sum>>LOG2_DEC. No rounding adder is synthesised.

Test Plan:
- Defaults, rst 2 cycles, then in_valid=1 with 10,20,30,42 and out_ready=1 -> one cycle after the 4th sample, out_valid=1 with out_data=25. With FIR_DEC_ROUND_EN, out_data=26. level returns to 0 after the pop.
- Gaps: samples 4,4,4,4 with in_valid toggling 1,0,1,0,... -> exactly one output of 4. Idle cycles do not advance the phase.
- Backpressure: out_ready=0, feed 20 samples of 255 -> level reaches 4 after 16 samples; dumps 5 drops 1 sample, overflow=1, drop_cnt=1. The FIFO holds four 255s, and these drain in order once out_ready=1.
- Full plus simultaneous: FIFO full, dump coincides with out_ready=1 -> push accepted, level stays 4, drop_cnt unchanged.
- Mid-accumulation reset: feed 2 samples, assert rst, then feed 8,8,8,8 -> single output of 8. Pre-reset samples are lost; all status outputs read 0 after reset.
- LOG2_DEC=0: inputs 7,200,255 with out_ready=1 -> outputs 7,200,255 each 1 cycle later. With LOG2_DEC=4, sixteen 255s -> output 255 in both macro builds.

Source files
------------

// File: rtl/fir_out_decimator_if.sv
// Bus bundle for fir_out_decimator: FIR sample input, decimated output handshake and status.
// Output handshake: a sample transfers on any rising edge where out_valid && out_ready;
// out_data stays stable while out_valid=1 and out_ready=0; in_valid has no backpressure.
interface fir_out_decimator_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, level, overflow, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, level, overflow, drop_cnt
    );
endinterface

// File: rtl/fir_out_decimator.sv
// Boxcar accumulate-and-dump decimator by 2^LOG2_DEC feeding a small output FIFO with drop counting.
// Optional macro FIR_DEC_ROUND_EN selects round-half-up instead of truncation.
module fir_out_decimator #(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEC   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input logic               clk,
    input logic               rst,
    fir_out_decimator_if.slave bus
);
    localparam int ACC_W = DATA_W + LOG2_DEC;
    localparam int PH_W  = (LOG2_DEC > 0) ? LOG2_DEC : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'((1 << LOG2_DEC) - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];

    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] result;
    logic              is_last, push_req, pop, push_ok, drop;

    assign sum      = acc_q + ACC_W'(bus.in_data);
    assign is_last  = (phase_q == PH_LAST);
    assign push_req = bus.in_valid & is_last;
    assign pop      = out_valid_q & bus.out_ready;
    assign push_ok  = push_req & ((level_q != LVL_FULL) | pop);
    assign drop     = push_req & (level_q == LVL_FULL) & ~pop;

`ifdef FIR_DEC_ROUND_EN
    localparam logic [ACC_W:0] RND_HALF = (ACC_W + 1)'((1 << LOG2_DEC) >> 1);
    localparam logic [ACC_W:0] RES_MAX  = (ACC_W + 1)'((1 << DATA_W) - 1);
    logic [ACC_W:0] rounded;

    // Extra bit keeps the rounding carry; the clamp guards against it reaching the output.
    always_comb begin
        rounded = ({1'b0, sum} + RND_HALF) >> LOG2_DEC;
        result  = (rounded > RES_MAX) ? {DATA_W{1'b1}} : rounded[DATA_W-1:0];
    end
`else
    assign result = sum[LOG2_DEC +: DATA_W];
`endif

    always_comb begin
        acc_d       = acc_q;
        phase_d     = phase_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        mem_d       = mem_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;

        if (bus.in_valid) begin
            if (is_last) begin
                acc_d   = '0;
                phase_d = '0;
            end else begin
                acc_d   = sum;
                phase_d = phase_q + 1'b1;
            end
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = result;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push_ok && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push_ok) begin
            level_d = level_q - 1'b1;
        end

        // A dump into a full FIFO with no pop is lost; the FIR upstream cannot be stalled.
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {CNT_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end

        out_valid_d = (level_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            phase_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            mem_q       <= '{default: '0};
        end else begin
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            mem_q       <= mem_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Bench for fir_out_decimator: default (LOG2_DEC=2) instance with a scoreboard model,
// plus LOG2_DEC=0 and LOG2_DEC=4 instances for the decimation-factor boundaries.
module tb_fir_out_decimator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_out_decimator_if #(.DATA_W(8), .FIFO_DEPTH(4), .CNT_W(8)) b2 ();
  fir_out_decimator_if #(.DATA_W(8), .FIFO_DEPTH(4), .CNT_W(8)) b0 ();
  fir_out_decimator_if #(.DATA_W(8), .FIFO_DEPTH(4), .CNT_W(8)) b4 ();

  fir_out_decimator #(.DATA_W(8), .LOG2_DEC(2), .FIFO_DEPTH(4), .CNT_W(8)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  fir_out_decimator #(.DATA_W(8), .LOG2_DEC(0), .FIFO_DEPTH(4), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  fir_out_decimator #(.DATA_W(8), .LOG2_DEC(4), .FIFO_DEPTH(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  int n_checks = 0;
  int n_fail = 0;

`ifdef FIR_DEC_ROUND_EN
  localparam logic [7:0] EXP_BASIC = 8'd26;
`else
  localparam logic [7:0] EXP_BASIC = 8'd25;
`endif

  function automatic logic [7:0] exp_avg(input int sum, input int l2);
    int r;
`ifdef FIR_DEC_ROUND_EN
    if (l2 > 0) r = (sum + (1 << (l2 - 1))) >> l2;
    else r = sum;
`else
    r = sum >> l2;
`endif
    if (r > 255) r = 255;
    return r[7:0];
  endfunction

  // Scoreboard model of the LOG2_DEC=2 instance, evaluated at each falling edge
  logic [7:0] exp_q[$];
  int m_acc = 0, m_phase = 0, m_level = 0, m_drop = 0;
  bit m_ovf = 1'b0;

  always @(negedge clk) begin
    bit pop, pushed;
    logic [7:0] exp_v;
    int s;
    if (rst) begin
      m_acc = 0; m_phase = 0; m_level = 0; m_drop = 0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      n_checks++;
      if (b2.level !== 3'(m_level)) begin
        n_fail++; $display("FAIL sb_level: got %0d expected %0d", b2.level, m_level);
      end
      n_checks++;
      if (b2.out_valid !== (m_level != 0)) begin
        n_fail++; $display("FAIL sb_out_valid: got %0b expected %0b", b2.out_valid, m_level != 0);
      end
      n_checks++;
      if (b2.drop_cnt !== 8'(m_drop) || b2.overflow !== m_ovf) begin
        n_fail++; $display("FAIL sb_drop: got cnt %0d ovf %0b expected cnt %0d ovf %0b",
                           b2.drop_cnt, b2.overflow, m_drop, m_ovf);
      end
      pop = (m_level != 0) && (b2.out_ready === 1'b1);
      pushed = 1'b0;
      if (pop) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sb_underflow: got pop expected empty queue to have data");
        end else begin
          exp_v = exp_q.pop_front();
          if (b2.out_data !== exp_v) begin
            n_fail++; $display("FAIL sb_data: got %0d expected %0d", b2.out_data, exp_v);
          end
        end
      end
      if (b2.in_valid === 1'b1) begin
        if (m_phase == 3) begin
          s = m_acc + int'(b2.in_data);
          m_acc = 0; m_phase = 0;
          if (m_level < 4 || pop) begin
            exp_q.push_back(exp_avg(s, 2));
            pushed = 1'b1;
          end else begin
            m_ovf = 1'b1;
            if (m_drop != 255) m_drop++;
          end
        end else begin
          m_acc += int'(b2.in_data);
          m_phase++;
        end
      end
      if (pushed && !pop) m_level++;
      else if (pop && !pushed) m_level--;
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    @(posedge clk); #2;
    b2.in_valid = v; b2.in_data = d; b2.out_ready = r;
  endtask

  task automatic drain(input string name);
    int k;
    drive(1'b0, 8'd0, 1'b1);
    k = 0;
    while (k < 20 && b2.level !== 3'd0) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_checks++;
    if (b2.level !== 3'd0 || b2.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_drain: got level %0d valid %0b expected level 0 valid 0", name, b2.level, b2.out_valid);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (b2.out_valid !== 1'b0 || b2.out_data !== 8'd0) begin
      n_fail++; $display("FAIL reset_out: got valid %0b data %0d expected 0 0", b2.out_valid, b2.out_data);
    end
    n_checks++;
    if (b2.level !== 3'd0 || b2.overflow !== 1'b0 || b2.drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_status: got level %0d ovf %0b cnt %0d expected 0 0 0", b2.level, b2.overflow, b2.drop_cnt);
    end
    n_checks++;
    if (b0.out_valid !== 1'b0 || b4.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_other: got %0b %0b expected 0 0", b0.out_valid, b4.out_valid);
    end
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    drive(1'b1, 8'd10, 1'b1);
    drive(1'b1, 8'd20, 1'b1);
    drive(1'b1, 8'd30, 1'b1);
    drive(1'b1, 8'd42, 1'b1);
    drive(1'b0, 8'd0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (b2.out_valid !== 1'b1 || b2.out_data !== EXP_BASIC) begin
      n_fail++; $display("FAIL basic_out: got valid %0b data %0d expected 1 %0d", b2.out_valid, b2.out_data, EXP_BASIC);
    end
    @(negedge clk);
    n_checks++;
    if (b2.level !== 3'd0) begin
      n_fail++; $display("FAIL basic_level: got %0d expected 0", b2.level);
    end
  endtask

  task automatic test_gaps;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'd4, 1'b1);
      drive(1'b0, 8'd0, 1'b1);
      if (i == 2) begin
        @(negedge clk);
        n_checks++;
        if (b2.out_valid !== 1'b0) begin
          n_fail++; $display("FAIL gaps_early: got valid %0b expected 0", b2.out_valid);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (b2.out_valid !== 1'b1 || b2.out_data !== 8'd4) begin
      n_fail++; $display("FAIL gaps_out: got valid %0b data %0d expected 1 4", b2.out_valid, b2.out_data);
    end
    drive(1'b0, 8'd0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (b2.level !== 3'd0) begin
      n_fail++; $display("FAIL gaps_level: got %0d expected 0", b2.level);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'd255, 1'b0);
      if (i == 16) begin
        @(negedge clk);
        n_checks++;
        if (b2.level !== 3'd4 || b2.overflow !== 1'b0) begin
          n_fail++; $display("FAIL bp_fill: got level %0d ovf %0b expected 4 0", b2.level, b2.overflow);
        end
      end
    end
    drive(1'b0, 8'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (b2.level !== 3'd4 || b2.overflow !== 1'b1 || b2.drop_cnt !== 8'd1) begin
      n_fail++; $display("FAIL bp_drop: got level %0d ovf %0b cnt %0d expected 4 1 1", b2.level, b2.overflow, b2.drop_cnt);
    end
    n_checks++;
    if (b2.out_data !== 8'd255) begin
      n_fail++; $display("FAIL bp_head: got %0d expected 255", b2.out_data);
    end
    drain("bp");
  endtask

  task automatic test_full_simul;
    for (int i = 0; i < 19; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    drive(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    drive(1'b0, 8'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (b2.level !== 3'd4 || b2.drop_cnt !== 8'd1) begin
      n_fail++; $display("FAIL full_simul: got level %0d cnt %0d expected 4 1", b2.level, b2.drop_cnt);
    end
    drain("full_simul");
  endtask

  task automatic test_mid_reset;
    drive(1'b1, 8'd100, 1'b1);
    drive(1'b1, 8'd100, 1'b1);
    drive(1'b0, 8'd0, 1'b1);
    rst = 1'b1;
    drive(1'b0, 8'd0, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b2.level !== 3'd0 || b2.overflow !== 1'b0 || b2.drop_cnt !== 8'd0 || b2.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_status: got level %0d ovf %0b cnt %0d valid %0b expected 0 0 0 0",
                         b2.level, b2.overflow, b2.drop_cnt, b2.out_valid);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 8'd8, 1'b1);
    drive(1'b0, 8'd0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (b2.out_valid !== 1'b1 || b2.out_data !== 8'd8) begin
      n_fail++; $display("FAIL mid_reset_out: got valid %0b data %0d expected 1 8", b2.out_valid, b2.out_data);
    end
    drain("mid_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0));
    end
    drain("random");
  endtask

  task automatic test_log2_0;
    logic [7:0] v [3];
    v[0] = 8'd7; v[1] = 8'd200; v[2] = 8'd255;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      b0.out_ready = 1'b1;
      b0.in_valid = (i < 3);
      b0.in_data = (i < 3) ? v[i] : 8'd0;
      if (i > 0) begin
        @(negedge clk);
        n_checks++;
        if (b0.out_valid !== 1'b1 || b0.out_data !== v[i-1] || b0.level !== 3'd1) begin
          n_fail++; $display("FAIL log2_0_out%0d: got valid %0b data %0d level %0d expected 1 %0d 1",
                             i - 1, b0.out_valid, b0.out_data, b0.level, v[i-1]);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (b0.level !== 3'd0) begin
      n_fail++; $display("FAIL log2_0_level: got %0d expected 0", b0.level);
    end
  endtask

  task automatic test_log2_4;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #2;
      b4.in_valid = 1'b1; b4.in_data = 8'd255; b4.out_ready = 1'b1;
      if (i == 15) begin
        @(negedge clk);
        n_checks++;
        if (b4.out_valid !== 1'b0) begin
          n_fail++; $display("FAIL log2_4_early: got valid %0b expected 0", b4.out_valid);
        end
      end
    end
    @(posedge clk); #2;
    b4.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b4.out_valid !== 1'b1 || b4.out_data !== 8'd255) begin
      n_fail++; $display("FAIL log2_4_out: got valid %0b data %0d expected 1 255", b4.out_valid, b4.out_data);
    end
  endtask

  initial begin
    b2.in_valid = 1'b0; b2.in_data = 8'd0; b2.out_ready = 1'b0;
    b0.in_valid = 1'b0; b0.in_data = 8'd0; b0.out_ready = 1'b0;
    b4.in_valid = 1'b0; b4.in_data = 8'd0; b4.out_ready = 1'b0;
    test_reset;
    test_basic;
    test_gaps;
    test_backpressure;
    test_full_simul;
    test_mid_reset;
    test_random;
    test_log2_0;
    test_log2_4;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
